// File: rtl/shift_reg_ctrl.sv
// ============================================================================
//  Module   : shift_reg_ctrl
//  Function : Sequencer for the 2-bit-per-base database shift register in the
//             BLAST seed-match path (load / shift / stop, hit hold-off).
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module shift_reg_ctrl #(
    parameter int DATA_W     = 512,
    parameter int BASE_W     = 2,
    parameter int WORD_BASES = DATA_W / BASE_W,
    parameter int POS_W      = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [15:0]       total_words,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              hit,
    input  logic              hit_ack,
    output logic              load,
    output logic              shift,
    output logic              stop,
    output logic [8:0]        shift_no,
    output logic [POS_W-1:0]  base_pos,
    output logic [POS_W-1:0]  hit_pos,
    output logic              busy,
    output logic              done
);

    localparam logic [8:0] LAST_SHIFT = 9'(WORD_BASES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_RUN   = 3'd2,
        S_HOLD  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        words_left_q, words_left_d;
    logic [8:0]         shift_no_q, shift_no_d;
    logic [POS_W-1:0]   base_pos_q, base_pos_d;
    logic [POS_W-1:0]   hit_pos_q, hit_pos_d;
    logic               boundary;

    assign boundary = (shift_no_q == LAST_SHIFT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            words_left_q <= '0;
            shift_no_q   <= '0;
            base_pos_q   <= '0;
            hit_pos_q    <= '0;
        end else begin
            state_q      <= state_d;
            words_left_q <= words_left_d;
            shift_no_q   <= shift_no_d;
            base_pos_q   <= base_pos_d;
            hit_pos_q    <= hit_pos_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        words_left_d = words_left_q;
        shift_no_d   = shift_no_q;
        base_pos_d   = base_pos_q;
        hit_pos_d    = hit_pos_q;
        in_ready     = 1'b0;
        load         = 1'b0;
        shift        = 1'b0;
        stop         = 1'b0;
        done         = 1'b0;
        busy         = (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (total_words != 16'd0) begin
                        words_left_d = total_words;
                        base_pos_d   = '0;
                        state_d      = S_FETCH;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_FETCH: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load         = 1'b1;
                    shift_no_d   = '0;
                    words_left_d = words_left_q - 16'd1;
                    state_d      = S_RUN;
                end
            end
            S_RUN: begin
                // A hit outranks everything, including a pending boundary load.
                if (hit) begin
                    stop      = 1'b1;
                    hit_pos_d = base_pos_q;
                    state_d   = S_HOLD;
                end else if (!boundary) begin
                    shift      = 1'b1;
                    shift_no_d = shift_no_q + 9'd1;
                    base_pos_d = base_pos_q + POS_W'(1);
                end else if (words_left_q == 16'd0) begin
                    state_d = S_DONE;
                end else begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        load         = 1'b1;
                        shift        = 1'b1;
                        shift_no_d   = '0;
                        base_pos_d   = base_pos_q + POS_W'(1);
                        words_left_d = words_left_q - 16'd1;
                    end
                end
            end
            S_HOLD: begin
                if (hit_ack) begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign shift_no = shift_no_q;
    assign base_pos = base_pos_q;
    assign hit_pos  = hit_pos_q;

endmodule

`default_nettype wire

// File: tb/tb_shift_reg_ctrl.sv
// ============================================================================
//  Module   : tb_shift_reg_ctrl
//  Function : Self-checking bench for shift_reg_ctrl (scan model + directed cases).
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_shift_reg_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] total_words = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        hit = 1'b0;
    logic        hit_ack = 1'b0;
    logic        load, shift, stop, busy, done;
    logic [8:0]  shift_no;
    logic [23:0] base_pos, hit_pos;

    int n_tests = 0;
    int n_fail  = 0;
    int cnt_load = 0, cnt_shift = 0, cnt_ready = 0, cnt_stop = 0, cnt_done = 0;

    shift_reg_ctrl #(.DATA_W(512), .BASE_W(2), .WORD_BASES(256), .POS_W(24)) dut (
        .clk(clk), .rst(rst), .start(start), .total_words(total_words),
        .in_valid(in_valid), .in_ready(in_ready), .hit(hit), .hit_ack(hit_ack),
        .load(load), .shift(shift), .stop(stop), .shift_no(shift_no),
        .base_pos(base_pos), .hit_pos(hit_pos), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scan model: words accepted vs. words requested, bases consumed in the word.
    int  m_active = 0, m_finish = 0, m_frozen = 0;
    int  m_total = 0, m_loaded = 0, m_offset = 0, m_pos = 0, m_hitpos = 0;

    initial forever begin
        logic run, fetch, at_end, e_rdy, e_load, e_shift, e_stop;
        @(negedge clk);
        if (!rst) begin
            m_active = 0; m_finish = 0; m_frozen = 0; m_total = 0;
            m_loaded = 0; m_offset = 0; m_pos = 0; m_hitpos = 0;
        end
        run     = (m_active != 0) && (m_frozen == 0) && (m_loaded > 0);
        fetch   = (m_active != 0) && (m_loaded == 0);
        at_end  = run && (m_offset == 255);
        e_rdy   = fetch || (at_end && !hit && (m_loaded < m_total));
        e_load  = e_rdy && in_valid;
        e_stop  = run && hit;
        e_shift = run && !hit && ((m_offset < 255) || e_load);
        check("cyc_strobes", {26'd0, in_ready, load, shift, stop, busy, done},
              {26'd0, e_rdy, e_load, e_shift, e_stop,
               ((m_active != 0) || (m_finish != 0)), (m_finish != 0)});
        check("cyc_shift_no", {23'd0, shift_no}, m_offset);
        check("cyc_base_pos", {8'd0, base_pos}, m_pos);
        check("cyc_hit_pos", {8'd0, hit_pos}, m_hitpos);
        if (rst) begin
            if (m_finish != 0) begin
                m_finish = 0;
            end else if (m_active == 0) begin
                if (start) begin
                    if (total_words == 16'd0) begin
                        m_finish = 1;
                    end else begin
                        m_active = 1; m_total = int'(total_words);
                        m_loaded = 0; m_pos = 0;
                    end
                end
            end else if (m_frozen != 0) begin
                if (hit_ack) m_frozen = 0;
            end else if (m_loaded == 0) begin
                if (e_load) begin m_loaded = 1; m_offset = 0; end
            end else if (hit) begin
                m_frozen = 1; m_hitpos = m_pos;
            end else if (m_offset < 255) begin
                m_offset++; m_pos = (m_pos + 1) % (1 << 24);
            end else if (m_loaded == m_total) begin
                m_finish = 1; m_active = 0;
            end else if (e_load) begin
                m_loaded++; m_offset = 0; m_pos = (m_pos + 1) % (1 << 24);
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst) begin
            cnt_load  += int'(load);
            cnt_shift += int'(shift);
            cnt_ready += int'(in_ready);
            cnt_stop  += int'(stop);
            cnt_done  += int'(done);
        end
    end

    task automatic wait_sn(input int v, input string nm);
        int n = 0;
        while (shift_no !== 9'(v) && n < 2000) begin tick(); n++; end
        check({"timeout_", nm}, (n < 2000), 1);
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        while (done !== 1'b1 && n < 2000) begin tick(); n++; end
        check({"timeout_", nm}, (n < 2000), 1);
    endtask

    task automatic begin_scan(input logic [15:0] nw, input logic valid);
        total_words = nw; in_valid = valid; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int b_load, b_shift, b_ready, b_stop, b_done;
        #2;
        check("reset_outputs", {in_ready, load, shift, stop, busy, done, shift_no, base_pos, hit_pos},
              '0);
        tick(); tick();
        rst = 1'b1;
        tick();

        // Single word
        b_load = cnt_load; b_shift = cnt_shift; b_ready = cnt_ready;
        begin_scan(16'd1, 1'b1);
        check("s1_first_load", {in_ready, load, busy}, 3'b111);
        tick();
        check("s1_run_sn0", {shift, shift_no}, {1'b1, 9'd0});
        start = 1'b1; total_words = 16'd7;
        tick();
        start = 1'b0;
        wait_done("s1");
        check("s1_base_pos_done", base_pos, 24'd255);
        check("s1_loads", cnt_load - b_load, 1);
        check("s1_shifts", cnt_shift - b_shift, 255);
        check("s1_ready_once", cnt_ready - b_ready, 1);
        tick();
        check("s1_idle", {busy, done}, 2'b00);

        // Two words back to back
        b_load = cnt_load; b_shift = cnt_shift;
        begin_scan(16'd2, 1'b1);
        tick();
        wait_sn(255, "s2");
        check("s2_merged", {load, shift, base_pos}, {2'b11, 24'd255});
        tick();
        check("s2_after_merge", {shift_no, base_pos}, {9'd0, 24'd256});
        wait_done("s2");
        check("s2_shifts", cnt_shift - b_shift, 511);
        check("s2_loads", cnt_load - b_load, 2);
        check("s2_base_pos_done", base_pos, 24'd511);
        tick();

        // Boundary stall of five cycles
        begin_scan(16'd2, 1'b1);
        tick();
        in_valid = 1'b0;
        wait_sn(255, "s3");
        for (int i = 0; i < 5; i++) begin
            check("s3_stall", {in_ready, load, shift, shift_no, base_pos},
                  {3'b100, 9'd255, 24'd255});
            tick();
        end
        in_valid = 1'b1;
        #1;
        check("s3_merged", {load, shift}, 2'b11);
        tick();
        check("s3_after_merge", {shift_no, base_pos}, {9'd0, 24'd256});
        wait_done("s3");
        check("s3_base_pos_done", base_pos, 24'd511);
        tick();

        // Hit mid-word, hit ignored in FETCH and HOLD
        b_stop = cnt_stop;
        hit = 1'b1;
        begin_scan(16'd1, 1'b0);
        check("s4_fetch_hit_ignored", {in_ready, load, stop}, 3'b100);
        tick();
        hit = 1'b0; in_valid = 1'b1;
        #1;
        check("s4_late_load", load, 1'b1);
        tick();
        wait_sn(40, "s4");
        hit = 1'b1;
        #1;
        check("s4_stop", {stop, shift, load, in_ready}, 4'b1000);
        tick();
        hit = 1'b0;
        check("s4_hold", {hit_pos, shift_no, stop, shift, busy}, {24'd40, 9'd40, 3'b001});
        for (int i = 0; i < 10; i++) begin
            hit = (i == 3);
            #1;
            check("s4_frozen", {stop, shift, shift_no}, {2'b00, 9'd40});
            tick();
        end
        hit = 1'b0; hit_ack = 1'b1;
        tick();
        hit_ack = 1'b0;
        check("s4_resume", {shift, shift_no}, {1'b1, 9'd40});
        tick();
        check("s4_sn41", shift_no, 9'd41);
        wait_done("s4");
        check("s4_one_stop", cnt_stop - b_stop, 1);
        check("s4_base_pos_done", base_pos, 24'd255);
        tick();

        // Hit exactly at the word boundary with a word on offer
        begin_scan(16'd2, 1'b1);
        tick();
        wait_sn(255, "s5");
        hit = 1'b1;
        #1;
        check("s5_hit_boundary", {stop, load, in_ready, shift}, 4'b1000);
        tick();
        hit = 1'b0;
        check("s5_hold", {stop, load, in_ready, hit_pos}, {3'b000, 24'd255});
        tick();
        hit_ack = 1'b1;
        tick();
        hit_ack = 1'b0;
        check("s5_load_after_ack", {load, shift, shift_no}, {2'b11, 9'd255});
        tick();
        check("s5_after_merge", {shift_no, base_pos}, {9'd0, 24'd256});
        wait_done("s5");
        check("s5_base_pos_done", base_pos, 24'd511);
        tick();

        // Zero-word scan
        b_load = cnt_load;
        begin_scan(16'd0, 1'b1);
        check("s6_done_pulse", {done, busy, load}, 3'b110);
        tick();
        check("s6_idle", {done, busy}, 2'b00);
        check("s6_no_load", cnt_load - b_load, 0);

        // Reset mid-scan
        b_done = cnt_done;
        begin_scan(16'd1, 1'b1);
        tick();
        wait_sn(100, "s7");
        rst = 1'b0;
        #1;
        check("s7_async_reset", {in_ready, load, shift, stop, busy, done, shift_no, base_pos},
              '0);
        tick(); tick(); tick();
        rst = 1'b1;
        tick(); tick();
        check("s7_idle_after", {busy, done}, 2'b00);
        check("s7_no_done", cnt_done - b_done, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/shift_reg_ctrl.md
Name: shift_reg_ctrl

Overview:
- Sequencer for the 2-bit-per-base database shift register in the BLAST seed-match path.
- Pulls 512-bit database words from an upstream valid/ready stream and issues load/shift/stop to the shift register, one base (2 bits) per cycle.
- Tracks the base offset inside the current word and the global base position.
- On a comparator hit, freezes the datapath and waits for the host to acknowledge before resuming.

Parameters:
- DATA_W, 512, width of one database word in bits
- BASE_W, 2, bits per nucleotide (shift step)
- WORD_BASES, 256, bases per word (DATA_W/BASE_W)
- POS_W, 24, width of the global base position counter

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- start  input  1  one-cycle pulse; begins a scan of total_words words
- total_words  input  16  number of words to scan; sampled on start
- in_valid  input  1  upstream word available
- in_ready  output  1  controller accepts a word this cycle
- hit  input  1  comparator match on the current window
- hit_ack  input  1  host releases HOLD
- load  output  1  load the upstream word into the shift register
- shift  output  1  shift the register by BASE_W bits
- stop  output  1  one-cycle freeze pulse to the shift register
- shift_no  output  9  shifts issued since the last load (0..255)
- base_pos  output  POS_W  global index of the base at register position 0
- hit_pos  output  POS_W  base_pos captured at the last hit
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse when the scan completes

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. All outputs 0: load, shift, stop, in_ready, done, busy, shift_no, base_pos, hit_pos. words_left=0.
- States: IDLE, FETCH, RUN, HOLD, DONE. Outputs are combinational from state and inputs; counters are registered.
- IDLE
  - start=1 with total_words!=0: words_left<=total_words, base_pos<=0, next state FETCH.
  - start=1 with total_words==0: next state DONE.
  - start is ignored in all states other than IDLE.
- FETCH
  - in_ready=1.
  - On in_valid=1: load=1, shift_no<=0, words_left<=words_left-1, next state RUN.
  - Otherwise wait in FETCH with load=0.
- RUN, shift_no<255, hit=0
  - shift=1, shift_no<=shift_no+1, base_pos<=base_pos+1.
- RUN, shift_no==255, hit=0 (word boundary)
  - words_left==0: shift=0, next state DONE.
  - words_left!=0: in_ready=1.
    - in_valid=1: load=1 and shift=1 in the same cycle (merged load/shift path), shift_no<=0, base_pos<=base_pos+1, words_left decremented.
    - in_valid=0: stall; load=0, shift=0, no counter change.
- RUN, hit=1
  - stop=1 for exactly that cycle; shift=0, load=0, in_ready=0.
  - hit_pos<=base_pos; next state HOLD.
  - hit has priority over boundary load: no word is accepted that cycle.
- HOLD
  - All strobes 0; counters frozen.
  - hit_ack=1: next state RUN. Shifting resumes the following cycle from the same shift_no.
  - hit during HOLD is ignored.
- DONE: done=1 for one cycle, next state IDLE. busy=0 from IDLE onward.
- hit is sampled only in RUN; it is ignored in IDLE, FETCH and DONE.
- base_pos wraps modulo 2^POS_W without flagging.
- Handshake: a word transfers only when in_valid&in_ready. in_ready never depends combinationally on hit except in RUN, where it is forced to 0 when hit=1.
- Latency:
  - start to first load: 1 cycle minimum (IDLE->FETCH, load in the FETCH cycle with in_valid=1).
  - Steady state: 256 cycles per word with no stalls.
- Reset mid-scan returns to IDLE immediately; no done pulse.

Test Plan:
- Single word: start, total_words=1, in_valid held 1.
  - Expect: load pulse, then 255 shift cycles (shift_no 1..255), then done pulse.
  - Expect: base_pos=255 at done; in_ready asserted exactly once.
- Two words back-to-back, in_valid=1.
  - Expect: at shift_no=255, load=1 and shift=1 in the same cycle.
  - Expect: shift_no returns to 0, base_pos=256 the next cycle.
  - Expect: done after 511 total shifts.
- Boundary stall: two words, in_valid=0 for 5 cycles at the boundary.
  - Expect: shift=0 and counters frozen for 5 cycles, then a merged load/shift.
- Hit mid-word: hit=1 at shift_no=40.
  - Expect: stop=1 for one cycle, hit_pos=40, state HOLD with shift=0.
  - Then hit_ack after 10 cycles: shifting resumes with shift_no 40->41.
- Hit at boundary with in_valid=1.
  - Expect: stop=1, load=0, in_ready=0.
  - After hit_ack, load occurs on the next RUN boundary cycle.
- Edge cases:
  - total_words=0: done pulses 1 cycle after start with no load.
  - rst=0 asserted during RUN: all outputs 0 asynchronously, state IDLE, no done pulse.
